// File: rtl/hazard_unit_pkg.sv
// Shared pipeline definitions for the hazard unit: register-address width,
// the r0 constant, the mult/div tracker state encoding and a register match helper.
package hazard_unit_pkg;

  localparam int REG_W = 5;
  localparam logic [REG_W-1:0] REG_ZERO = '0;

  typedef enum logic {
    MD_IDLE = 1'b0,
    MD_BUSY = 1'b1
  } md_state_t;

  // r0 is hardwired to zero, so a match on it never creates a dependency.
  function automatic logic reg_match(input logic [REG_W-1:0] dst, input logic [REG_W-1:0] src);
    return (dst != REG_ZERO) && (dst == src);
  endfunction

endpackage

// File: rtl/hazard_unit_if.sv
// Pipeline-to-hazard-unit signal bundle. All signals are plain levels sampled
// every cycle; there is no valid/ready handshake on this bus.
interface hazard_unit_if #(
  parameter int CNT_W = 32
) ();
  import hazard_unit_pkg::*;

  logic [REG_W-1:0] ifid_rs;
  logic [REG_W-1:0] ifid_rt;
  logic             ifid_uses_rt;
  logic             id_branch;
  logic             id_mfhilo;
  logic             id_md;
  logic             idex_memread;
  logic             idex_regwrite;
  logic [REG_W-1:0] idex_rt;
  logic [REG_W-1:0] idex_rd;
  logic             exmem_memread;
  logic [REG_W-1:0] exmem_rd;
  logic             ex_md_start;
  logic             branch_taken;
  logic             jump;

  logic             pc_write;
  logic             ifid_write;
  logic             idex_flush;
  logic             ifid_flush;
  logic             md_busy;
  logic             md_done;
  logic             md_overlap_err;
  logic [CNT_W-1:0] stall_count;
  md_state_t        md_state;

  modport master (
    output ifid_rs, ifid_rt, ifid_uses_rt, id_branch, id_mfhilo, id_md,
           idex_memread, idex_regwrite, idex_rt, idex_rd,
           exmem_memread, exmem_rd, ex_md_start, branch_taken, jump,
    input  pc_write, ifid_write, idex_flush, ifid_flush,
           md_busy, md_done, md_overlap_err, stall_count, md_state
  );

  modport slave (
    input  ifid_rs, ifid_rt, ifid_uses_rt, id_branch, id_mfhilo, id_md,
           idex_memread, idex_regwrite, idex_rt, idex_rd,
           exmem_memread, exmem_rd, ex_md_start, branch_taken, jump,
    output pc_write, ifid_write, idex_flush, ifid_flush,
           md_busy, md_done, md_overlap_err, stall_count, md_state
  );

endinterface

// File: rtl/hazard_unit_md_tracker.sv
// Tracks the iterative mult/div unit: HI/LO busy window, last-cycle done pulse
// and a sticky flag for a start that arrives while the unit is still busy.
module hazard_unit_md_tracker
  import hazard_unit_pkg::*;
#(
  parameter int MD_LATENCY = 32
) (
  input  logic      clk,
  input  logic      rst,
  input  logic      ex_md_start,
  output logic      md_busy,
  output logic      md_done,
  output logic      md_overlap_err,
  output md_state_t md_state
);

  localparam logic [7:0] MD_LOAD = 8'(MD_LATENCY - 1);

  md_state_t  state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic       err_q, err_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= MD_IDLE;
      cnt_q   <= 8'd0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    md_done = 1'b0;
    case (state_q)
      MD_IDLE: begin
        if (ex_md_start) begin
          state_d = MD_BUSY;
          cnt_d   = MD_LOAD;
        end
      end
      MD_BUSY: begin
        // A second start while busy is dropped; the running count is untouched.
        if (ex_md_start) err_d = 1'b1;
        if (cnt_q <= 8'd1) begin
          md_done = 1'b1;
          state_d = MD_IDLE;
          cnt_d   = 8'd0;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      default: begin
        state_d = MD_IDLE;
        cnt_d   = 8'd0;
      end
    endcase
  end

  assign md_busy        = (state_q == MD_BUSY);
  assign md_overlap_err = err_q;
  assign md_state       = state_q;

endmodule

// File: rtl/hazard_unit.sv
// Stall/flush controller for the 5-stage pipeline: load-use, branch-in-ID and
// mult/div stalls, redirect flush of IF/ID, and a saturating stall-cycle counter.
module hazard_unit
  import hazard_unit_pkg::*;
#(
  parameter int MD_LATENCY = 32,
  parameter int CNT_W      = 32
) (
  input logic         clk,
  input logic         rst,
  hazard_unit_if.slave hu
);

  logic             lw_stall;
  logic             br_stall;
  logic             md_stall;
  logic             stall;
  logic             md_busy;
  logic [CNT_W-1:0] stall_cnt_q;

  hazard_unit_md_tracker #(
    .MD_LATENCY(MD_LATENCY)
  ) u_md_tracker (
    .clk           (clk),
    .rst           (rst),
    .ex_md_start   (hu.ex_md_start),
    .md_busy       (md_busy),
    .md_done       (hu.md_done),
    .md_overlap_err(hu.md_overlap_err),
    .md_state      (hu.md_state)
  );

  assign lw_stall = hu.idex_memread &&
                    (reg_match(hu.idex_rt, hu.ifid_rs) ||
                     (hu.ifid_uses_rt && reg_match(hu.idex_rt, hu.ifid_rt)));

  // The branch compare happens in ID, so an ALU result still in EX or a load
  // still in MEM cannot be bypassed into it in time.
  assign br_stall = hu.id_branch &&
                    ((hu.idex_regwrite &&
                      (reg_match(hu.idex_rd, hu.ifid_rs) || reg_match(hu.idex_rd, hu.ifid_rt))) ||
                     (hu.exmem_memread &&
                      (reg_match(hu.exmem_rd, hu.ifid_rs) || reg_match(hu.exmem_rd, hu.ifid_rt))));

  assign md_stall = md_busy && (hu.id_mfhilo || hu.id_md);
  assign stall    = lw_stall || br_stall || md_stall;

  assign hu.pc_write   = !stall;
  assign hu.ifid_write = !stall;
  assign hu.idex_flush = stall;
  // Stall wins over a redirect: the branch is re-evaluated once operands arrive.
  assign hu.ifid_flush = (hu.branch_taken || hu.jump) && !stall;
  assign hu.md_busy    = md_busy;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt_q <= '0;
    end else if (stall && (stall_cnt_q != {CNT_W{1'b1}})) begin
      stall_cnt_q <= stall_cnt_q + CNT_W'(1);
    end
  end

  assign hu.stall_count = stall_cnt_q;

endmodule

// File: tb/tb_hazard_unit.sv
// Directed bench for hazard_unit: decode vector table plus hand-written
// mult/div, saturation and asynchronous-reset sequences.
module tb_hazard_unit;

  localparam int MD_LAT = 4;
  localparam int CW     = 4;
  localparam logic [CW-1:0] CNT_MAX = 4'hF;

  typedef struct {
    logic [4:0] rs;
    logic [4:0] rt;
    logic       uses_rt;
    logic       branch;
    logic       mfhilo;
    logic       md;
    logic       idex_memread;
    logic       idex_regwrite;
    logic [4:0] idex_rt;
    logic [4:0] idex_rd;
    logic       exmem_memread;
    logic [4:0] exmem_rd;
    logic       md_start;
    logic       branch_taken;
    logic       jump;
    logic       exp_stall;
    logic       exp_ifid_flush;
    logic       exp_busy;
    logic       exp_done;
  } vec_t;

  logic clk;
  logic rst;
  int   checks;
  int   failures;
  logic          exp_err;
  logic [CW-1:0] exp_cnt;
  logic [CW-1:0] exp_q[$];
  vec_t          tbl[$];

  hazard_unit_if #(.CNT_W(CW)) hu_if ();

  hazard_unit #(
    .MD_LATENCY(MD_LAT),
    .CNT_W     (CW)
  ) dut (
    .clk(clk),
    .rst(rst),
    .hu (hu_if)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  function automatic vec_t zv();
    vec_t v;
    v = '{default: '0};
    return v;
  endfunction

  task automatic drive(input vec_t v);
    hu_if.ifid_rs       = v.rs;
    hu_if.ifid_rt       = v.rt;
    hu_if.ifid_uses_rt  = v.uses_rt;
    hu_if.id_branch     = v.branch;
    hu_if.id_mfhilo     = v.mfhilo;
    hu_if.id_md         = v.md;
    hu_if.idex_memread  = v.idex_memread;
    hu_if.idex_regwrite = v.idex_regwrite;
    hu_if.idex_rt       = v.idex_rt;
    hu_if.idex_rd       = v.idex_rd;
    hu_if.exmem_memread = v.exmem_memread;
    hu_if.exmem_rd      = v.exmem_rd;
    hu_if.ex_md_start   = v.md_start;
    hu_if.branch_taken  = v.branch_taken;
    hu_if.jump          = v.jump;
  endtask

  // Called just after a rising edge; checks decode at the falling edge and the
  // counter just after the next rising edge.
  task automatic step(input vec_t v, input string tag);
    logic [CW-1:0] exp_c;
    drive(v);
    @(negedge clk);
    chk({tag, ".pc_write"},   32'(hu_if.pc_write),       32'(!v.exp_stall));
    chk({tag, ".ifid_write"}, 32'(hu_if.ifid_write),     32'(!v.exp_stall));
    chk({tag, ".idex_flush"}, 32'(hu_if.idex_flush),     32'(v.exp_stall));
    chk({tag, ".ifid_flush"}, 32'(hu_if.ifid_flush),     32'(v.exp_ifid_flush));
    chk({tag, ".md_busy"},    32'(hu_if.md_busy),        32'(v.exp_busy));
    chk({tag, ".md_done"},    32'(hu_if.md_done),        32'(v.exp_done));
    chk({tag, ".overlap"},    32'(hu_if.md_overlap_err), 32'(exp_err));
    if (v.exp_stall && exp_cnt != CNT_MAX) exp_cnt = exp_cnt + 4'd1;
    exp_q.push_back(exp_cnt);
    @(posedge clk);
    #1;
    exp_c = exp_q.pop_front();
    chk({tag, ".stall_count"}, 32'(hu_if.stall_count), 32'(exp_c));
  endtask

  initial begin
    vec_t v;
    checks   = 0;
    failures = 0;
    exp_err  = 1'b0;
    exp_cnt  = '0;
    rst      = 1'b1;
    drive(zv());

    // reset state, checked both before and across a clock edge
    #3;
    chk("rst.md_busy",     32'(hu_if.md_busy),     32'd0);
    chk("rst.md_done",     32'(hu_if.md_done),     32'd0);
    chk("rst.pc_write",    32'(hu_if.pc_write),    32'd1);
    chk("rst.ifid_write",  32'(hu_if.ifid_write),  32'd1);
    chk("rst.idex_flush",  32'(hu_if.idex_flush),  32'd0);
    chk("rst.ifid_flush",  32'(hu_if.ifid_flush),  32'd0);
    chk("rst.overlap",     32'(hu_if.md_overlap_err), 32'd0);
    @(posedge clk);
    #1;
    chk("rst.stall_count", 32'(hu_if.stall_count), 32'd0);
    @(negedge clk);
    #2;
    rst = 1'b0;
    @(posedge clk);
    #1;

    // decode table
    v = zv(); v.idex_memread = 1; v.idex_rt = 8; v.rs = 8; v.exp_stall = 1; tbl.push_back(v);
    v = zv(); v.idex_memread = 1; v.idex_rt = 0; v.rs = 0; tbl.push_back(v);
    v = zv(); v.idex_memread = 1; v.idex_rt = 8; v.rt = 8; v.rs = 3; tbl.push_back(v);
    v = zv(); v.idex_memread = 1; v.idex_rt = 8; v.rt = 8; v.rs = 3; v.uses_rt = 1; v.exp_stall = 1; tbl.push_back(v);
    v = zv(); v.branch = 1; v.rt = 9; v.uses_rt = 1; v.idex_memread = 1; v.idex_regwrite = 1;
              v.idex_rt = 9; v.idex_rd = 9; v.branch_taken = 1; v.exp_stall = 1; tbl.push_back(v);
    v = zv(); v.branch = 1; v.rt = 9; v.uses_rt = 1; v.exmem_memread = 1; v.exmem_rd = 9;
              v.branch_taken = 1; v.exp_stall = 1; tbl.push_back(v);
    v = zv(); v.branch = 1; v.rt = 9; v.uses_rt = 1; v.branch_taken = 1; v.exp_ifid_flush = 1; tbl.push_back(v);
    v = zv(); v.jump = 1; v.exp_ifid_flush = 1; tbl.push_back(v);
    v = zv(); v.branch = 1; v.idex_regwrite = 1; v.idex_rd = 5; v.rs = 5; v.exp_stall = 1; tbl.push_back(v);
    v = zv(); v.idex_regwrite = 1; v.idex_rd = 5; v.rs = 5; tbl.push_back(v);
    v = zv(); v.branch = 1; v.exmem_rd = 5; v.rs = 5; tbl.push_back(v);
    v = zv(); v.branch = 1; v.idex_regwrite = 1; v.idex_rd = 0; v.rs = 0; v.rt = 0; tbl.push_back(v);
    v = zv(); v.mfhilo = 1; v.md = 1; tbl.push_back(v);
    v = zv(); v.branch = 1; v.idex_regwrite = 1; v.idex_rd = 12; v.rt = 12; v.rs = 1; v.exp_stall = 1; tbl.push_back(v);
    v = zv(); v.branch = 1; v.exmem_memread = 1; v.exmem_rd = 0; v.rs = 0; v.jump = 1; v.exp_ifid_flush = 1; tbl.push_back(v);

    foreach (tbl[i]) step(tbl[i], $sformatf("vec%0d", i));

    // mult/div: start at edge 0, mfhi held in ID, overlapping start in cycle 2
    v = zv(); v.mfhilo = 1; v.md_start = 1; step(v, "md.c0");
    v = zv(); v.mfhilo = 1; v.exp_stall = 1; v.exp_busy = 1; step(v, "md.c1");
    v = zv(); v.mfhilo = 1; v.md_start = 1; v.exp_stall = 1; v.exp_busy = 1; step(v, "md.c2");
    exp_err = 1'b1;
    v = zv(); v.mfhilo = 1; v.exp_stall = 1; v.exp_busy = 1; v.exp_done = 1; step(v, "md.c3");
    v = zv(); v.mfhilo = 1; step(v, "md.c4");
    v = zv(); step(v, "md.sticky");

    // saturation of the stall counter
    for (int k = 0; k < 20; k++) begin
      v = zv(); v.idex_memread = 1; v.idex_rt = 17; v.rs = 17; v.exp_stall = 1;
      step(v, $sformatf("sat%0d", k));
    end
    chk("sat.final", 32'(hu_if.stall_count), 32'(CNT_MAX));

    // asynchronous reset in the middle of a busy window
    v = zv(); v.md = 1; v.md_start = 1; step(v, "ar.c0");
    v = zv(); v.md = 1; v.exp_stall = 1; v.exp_busy = 1; step(v, "ar.c1");
    v = zv(); v.md = 1;
    drive(v);
    #2;
    rst = 1'b1;
    #1;
    chk("ar.md_busy",     32'(hu_if.md_busy),        32'd0);
    chk("ar.md_done",     32'(hu_if.md_done),        32'd0);
    chk("ar.stall_count", 32'(hu_if.stall_count),    32'd0);
    chk("ar.overlap",     32'(hu_if.md_overlap_err), 32'd0);
    chk("ar.pc_write",    32'(hu_if.pc_write),       32'd1);
    exp_err = 1'b0;
    exp_cnt = '0;
    exp_q.delete();
    @(negedge clk);
    #2;
    rst = 1'b0;
    @(posedge clk);
    #1;

    // full count after reset release
    v = zv(); v.md = 1; v.md_start = 1; step(v, "rs.c0");
    v = zv(); v.md = 1; v.exp_stall = 1; v.exp_busy = 1; step(v, "rs.c1");
    v = zv(); v.md = 1; v.exp_stall = 1; v.exp_busy = 1; step(v, "rs.c2");
    v = zv(); v.md = 1; v.exp_stall = 1; v.exp_busy = 1; v.exp_done = 1; step(v, "rs.c3");
    v = zv(); v.md = 1; step(v, "rs.c4");
    chk("rs.total", 32'(hu_if.stall_count), 32'd3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/hazard_unit.md
# hazard_unit

Stall/flush controller for the 5-stage MIPS pipeline. It is the companion to operand forwarding: where bypassing cannot deliver a result in time, this block holds PC and IF/ID and injects an ID/EX bubble. Cases covered: load-use, branch-operand-in-ID, and an iterative multiply/divide unit. It also flushes IF/ID on taken branches and jumps, and keeps a stall-cycle counter.

## Interface
Parameters:
- MD_LATENCY, 32, cycles a mult/div occupies HI/LO; legal range 2..255.
- CNT_W, 32, width of the stall counter.

Ports:
- clk  in  1  pipeline clock; one clock.
- rst  in  1  asynchronous, active-high reset.
- ifid_rs, ifid_rt  in  5 each  source registers of the instruction in ID.
- ifid_uses_rt  in  1  ID instruction reads rt as a source.
- id_branch  in  1  ID holds a beq/bne; its comparison is done in ID.
- id_mfhilo  in  1  ID holds mfhi/mflo.
- id_md  in  1  ID holds mult/div.
- idex_memread, idex_regwrite  in  1 each  EX-stage controls.
- idex_rt, idex_rd  in  5 each  EX-stage load target and write destination.
- exmem_memread  in  1  MEM stage holds a load.
- exmem_rd  in  5  MEM-stage destination.
- ex_md_start  in  1  a mult/div is in EX this cycle.
- branch_taken, jump  in  1 each  redirect resolved in ID.
- pc_write, ifid_write  out  1 each  enables for PC and IF/ID; low while stalling.
- idex_flush  out  1  zero ID/EX controls (bubble).
- ifid_flush  out  1  zero the IF/ID instruction.
- md_busy  out  1  HI/LO not yet valid.
- md_done  out  1  one-cycle pulse on the last busy cycle.
- md_overlap_err  out  1  sticky; a new ex_md_start arrived while busy.
- stall_count  out  CNT_W  number of stalled cycles.

## Operation
A register matches only if it is nonzero; r0 never causes a stall.

- lw_stall: idex_memread and idex_rt matches ifid_rs, or matches ifid_rt when ifid_uses_rt is set.
- br_stall: id_branch and either of these holds:
  - idex_regwrite and idex_rd matches rs or rt;
  - exmem_memread and exmem_rd matches rs or rt.
- A branch behind a load in EX gets 2 stall cycles: the first via the EX term, the second via the MEM term.
- md_stall: md_busy and (id_mfhilo or id_md).
- stall is the OR of lw_stall, br_stall and md_stall.
- While stall is high: pc_write=0, ifid_write=0, idex_flush=1.
- ifid_flush = (branch_taken or jump) and not stall. Stall has priority, so the redirect is retried once operands are ready.

FSM states IDLE and BUSY, with an 8-bit down-counter md_cnt:
- IDLE, ex_md_start=1: go to BUSY, md_cnt = MD_LATENCY-1.
- BUSY, md_cnt>1: decrement md_cnt.
- BUSY, md_cnt=1: md_done=1 for this cycle; next state IDLE, md_cnt=0.
- BUSY, ex_md_start=1: set md_overlap_err; the start is ignored and the count continues.
- md_busy = (state==BUSY).

stall_count increments on every cycle where stall=1 and saturates at all-ones.

## Timing
- Stall decode, flush decode, md_busy and md_done are combinational from inputs and the current state. They are valid in the same cycle, with no added latency.
- State, md_cnt, md_overlap_err and stall_count update on the rising clk edge.
- Reset (asynchronous, mid-operation included) forces state=IDLE, md_cnt=0, md_overlap_err=0, stall_count=0.
- During and right after reset: md_busy=0 and md_done=0. pc_write=1, ifid_write=1, idex_flush=0 and ifid_flush=0 unless the inputs request otherwise.
- With ex_md_start at edge N: md_busy is high from cycle N+1 to N+MD_LATENCY-1, and md_done pulses in cycle N+MD_LATENCY-1. An mfhi in ID is released in cycle N+MD_LATENCY.
- Simultaneous lw_stall, br_stall and md_stall: a single stall, with stall_count +1.

## Structure
- Shared pipeline package holds:
  - the FSM state encoding (IDLE=0, BUSY=1);
  - the REG_ZERO constant;
  - the register-address width (5).
- One natural sub-module, md_tracker: the FSM, counter, md_done and overlap flag.
- Stall/flush decode and the stall counter stay in the top level.

## Test plan
- Load-use: idex_memread=1, idex_rt=8, ifid_rs=8 → one cycle with pc_write=0, ifid_write=0, idex_flush=1; stall_count goes 0→1. Repeat with idex_rt=0 → no stall.
- Branch after load: id_branch=1, ifid_rt=9, ifid_uses_rt=1, load to r9 in EX → stall. Next cycle, exmem_memread=1, exmem_rd=9 → stall again. Total stall_count=2.
- Redirect vs stall: branch_taken=1 with br_stall=1 → ifid_flush=0. Next cycle, no hazard and branch_taken=1 → ifid_flush=1, pc_write=1.
- Mult/div with MD_LATENCY=4: ex_md_start at edge 0; id_mfhilo=1 held → stall in cycles 1–3, md_done in cycle 3, release in cycle 4. A second ex_md_start in cycle 2 → md_overlap_err=1, sticky.
- Reset mid-BUSY: assert rst at cycle 2 of 32 → md_busy=0 and stall_count=0 immediately, without waiting for clk. After release, ex_md_start restarts a full count.
